alib_square_seq: RTL and testbench

ALIB_SQUARE_SEQ -- requirements
Module: alib_square_seq

---
 rtl/alib_square_seq.sv | 116 +++++++++++
 tb/tb_alib_square_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alib_square_seq.sv
// Purpose : sequential unsigned squarer using shift-add, one partial product per cycle.
// Latency : fixed IN_W+1 cycles from accept to out_valid (18 at IN_W=17), independent of operand.
// Backpr. : result held in DONE until out_ready; in_ready only in IDLE, no accept-on-complete.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_value/in_valid/in_ready    - operand handshake (IN_W bits, unsigned)
//   out_value/out_ovf/out_valid/out_ready - result handshake (RES_W = 2*IN_W-1 bits)
//
// Compile-time option:
//   ALIB_SQUARE_SAT_EN - when defined, out_value saturates to all-ones on overflow;
//                        otherwise out_value is the square modulo 2^RES_W.
module alib_square_seq #(
  parameter  int IN_W  = 17,
  localparam int RES_W = 2*IN_W-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [RES_W-1:0] out_value,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int ACC_W = 2*IN_W;
  localparam int CNT_W = $clog2(IN_W+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mcand;
  logic [IN_W-1:0]    mplier;
  logic [CNT_W-1:0]   cnt;
  logic [RES_W-1:0]   res_value;
  logic               iter_done;

  // The counter reaching IN_W means all partial products are in; CALC then
  // spends one more cycle registering the result, giving the IN_W+1 latency.
  assign iter_done = (cnt == CNT_W'(IN_W));

`ifdef ALIB_SQUARE_SAT_EN
  always_comb begin
    res_value = acc[RES_W-1:0];
    if (acc[ACC_W-1]) res_value = '1;
  end
`else
  always_comb begin
    res_value = acc[RES_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (iter_done) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      out_value <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= ACC_W'(in_value);
            mplier <= in_value;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!iter_done) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end else begin
            // Top accumulator bit set means the square needs 2*IN_W bits.
            out_value <= res_value;
            out_ovf   <= acc[ACC_W-1];
          end
        end
        default: ;  // DONE holds the registered result
      endcase
    end
  end

endmodule

// File: tb/tb_alib_square_seq.sv
module tb_alib_square_seq;

  logic        clk;
  logic        rst_n;
  logic [16:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] out_value;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  alib_square_seq #(.IN_W(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_value  (in_value),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand at a negedge, then waits (bounded) for out_valid.
  // lat counts rising edges from the accept edge to out_valid being seen.
  task automatic run_op(input logic [16:0] v, input bit noise,
                        output logic [32:0] rv, output logic ro, output int lat);
    @(negedge clk);
    in_value = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_value = '0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (noise) begin
        in_valid = lat[0];
        in_value = 17'(int'(v) + lat*7 + 1);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    rv = out_value;
    ro = out_ovf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (out_value !== 33'd0) begin failures++; $display("FAIL reset_out_value got=%0h exp=0", out_value); end
    checks++; if (out_ovf !== 1'b0)    begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero();
    logic [32:0] rv; logic ro; int lat;
    run_op(17'd0, 1'b0, rv, ro, lat);
    checks++; if (lat !== 18)       begin failures++; $display("FAIL zero_latency got=%0d exp=18", lat); end
    checks++; if (rv !== 33'd0)     begin failures++; $display("FAIL zero_value got=%0h exp=0", rv); end
    checks++; if (ro !== 1'b0)      begin failures++; $display("FAIL zero_ovf got=%b exp=0", ro); end
    release_out();
  endtask

  task automatic test_values();
    logic [32:0] rv; logic ro; int lat;
    run_op(17'd65535, 1'b0, rv, ro, lat);
    checks++; if (lat !== 18)             begin failures++; $display("FAIL v65535_latency got=%0d exp=18", lat); end
    checks++; if (rv !== 33'h0FFFE0001)   begin failures++; $display("FAIL v65535_value got=%0h exp=0fffe0001", rv); end
    checks++; if (ro !== 1'b0)            begin failures++; $display("FAIL v65535_ovf got=%b exp=0", ro); end
    release_out();
    run_op(17'd65536, 1'b0, rv, ro, lat);
    checks++; if (rv !== 33'h100000000)   begin failures++; $display("FAIL v65536_value got=%0h exp=100000000", rv); end
    checks++; if (ro !== 1'b0)            begin failures++; $display("FAIL v65536_ovf got=%b exp=0", ro); end
    release_out();
  endtask

  task automatic test_ovf();
    logic [32:0] rv; logic ro; int lat;
    logic [32:0] exp_v;
`ifdef ALIB_SQUARE_SAT_EN
    exp_v = 33'h1FFFFFFFF;
`else
    exp_v = 33'h1FFFC0001;
`endif
    run_op(17'd131071, 1'b0, rv, ro, lat);
    checks++; if (ro !== 1'b1)   begin failures++; $display("FAIL ovf_flag got=%b exp=1", ro); end
    checks++; if (rv !== exp_v)  begin failures++; $display("FAIL ovf_value got=%0h exp=%0h", rv, exp_v); end
    release_out();
  endtask

  task automatic test_back_pressure();
    logic [32:0] rv; logic ro; int lat;
    run_op(17'd300, 1'b0, rv, ro, lat);
    checks++; if (rv !== 33'd90000) begin failures++; $display("FAIL bp_value got=%0d exp=90000", rv); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_value !== 33'd90000) begin failures++; $display("FAIL bp_hold_value cyc=%0d got=%0d exp=90000", i, out_value); end
      checks++; if (out_valid !== 1'b1)      begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)       begin failures++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_value  = 17'd7;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_handshake_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_after_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_ignore_inputs();
    logic [32:0] rv; logic ro; int lat;
    run_op(17'd12345, 1'b1, rv, ro, lat);
    checks++; if (lat !== 18)             begin failures++; $display("FAIL noise_latency got=%0d exp=18", lat); end
    checks++; if (rv !== 33'd152399025)   begin failures++; $display("FAIL noise_value got=%0d exp=152399025", rv); end
    release_out();
  endtask

  task automatic test_mid_reset();
    logic [32:0] rv; logic ro; int lat;
    int seen;
    @(negedge clk);
    in_value = 17'd5000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_during_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_stale_result got=%0d exp=0", seen); end
    run_op(17'd3, 1'b0, rv, ro, lat);
    checks++; if (rv !== 33'd9) begin failures++; $display("FAIL midrst_next_value got=%0d exp=9", rv); end
    checks++; if (ro !== 1'b0)  begin failures++; $display("FAIL midrst_next_ovf got=%b exp=0", ro); end
    release_out();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_value  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_zero();
    test_values();
    test_ovf();
    test_back_pressure();
    test_ignore_inputs();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
